// File: rtl/execute_stage_if.sv
//------------------------------------------------------------------------------
// execute_stage_if : E-stage control/data inputs and E->M register outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface execute_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              RegWriteE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              ALUSrcE;
  logic              BranchE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1_E;
  logic [XLEN-1:0]   RD2_E;
  logic [XLEN-1:0]   Imm_Ext_E;
  logic [REG_AW-1:0] RD_E;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [XLEN-1:0]   ResultW;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallE;
  logic              FlushE;

  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [REG_AW-1:0] RD_M;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   WriteDataM;
  logic [XLEN-1:0]   PCPlus4M;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
           ForwardAE, ForwardBE, StallE, FlushE,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
           ForwardAE, ForwardBE, StallE, FlushE,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

`default_nettype wire

// File: rtl/execute_stage.sv
//------------------------------------------------------------------------------
// execute_stage : RV32I E stage - forwarding muxes, ALU, BEQ resolve, E->M reg
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module execute_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   fwd_b;
  logic [XLEN-1:0]   src_b;
  logic [XLEN-1:0]   alu_result;

  logic              regwrite_q,  regwrite_d;
  logic              memwrite_q,  memwrite_d;
  logic              resultsrc_q, resultsrc_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic [XLEN-1:0]   alu_q,       alu_d;
  logic [XLEN-1:0]   wdata_q,     wdata_d;
  logic [XLEN-1:0]   pc4_q,       pc4_d;

  // Code 11 is unused by the hazard unit and falls back to the register file.
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = alu_q;
      default: src_a = bus.RD1_E;
    endcase
    case (bus.ForwardBE)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = alu_q;
      default: fwd_b = bus.RD2_E;
    endcase
    src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
  end

  always_comb begin
    case (bus.ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result = src_a << src_b[SHW-1:0];
      default: alu_result = src_a >> src_b[SHW-1:0];
    endcase
  end

  assign bus.PCSrcE    = bus.BranchE & (alu_result == '0);
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Flush clears only the controls and destination; data still loads so the
  // bubble is harmless whatever it carries.
  always_comb begin
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    resultsrc_d = resultsrc_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    pc4_d       = pc4_q;
    if (bus.FlushE) begin
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      resultsrc_d = 1'b0;
      rd_d        = '0;
      alu_d       = alu_result;
      wdata_d     = fwd_b;
      pc4_d       = bus.PCPlus4E;
    end else if (!bus.StallE) begin
      regwrite_d  = bus.RegWriteE;
      memwrite_d  = bus.MemWriteE;
      resultsrc_d = bus.ResultSrcE;
      rd_d        = bus.RD_E;
      alu_d       = alu_result;
      wdata_d     = fwd_b;
      pc4_d       = bus.PCPlus4E;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pc4_q       <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      pc4_q       <= pc4_d;
    end
  end

  assign bus.RegWriteM  = regwrite_q;
  assign bus.MemWriteM  = memwrite_q;
  assign bus.ResultSrcM = resultsrc_q;
  assign bus.RD_M       = rd_q;
  assign bus.ALUResultM = alu_q;
  assign bus.WriteDataM = wdata_q;
  assign bus.PCPlus4M   = pc4_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
//------------------------------------------------------------------------------
// tb_execute_stage : directed vectors with a queue-based scoreboard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_execute_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  execute_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          cc;
    logic        pcsrc;
    logic [31:0] pct;
    bit          cd;
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic mw, input logic rs,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] wd, input logic [31:0] pc4);
    exp_t e;
    e.cc = 0; e.pcsrc = 1'b0; e.pct = '0;
    e.cd = 1; e.rw = rw; e.mw = mw; e.rs = rs; e.rd = rd;
    e.alu = alu; e.wd = wd; e.pc4 = pc4;
    return e;
  endfunction

  function automatic exp_t wc(input exp_t e, input logic pcsrc, input logic [31:0] pct);
    exp_t r = e;
    r.cc = 1; r.pcsrc = pcsrc; r.pct = pct;
    return r;
  endfunction

  // Called at a falling edge once inputs are applied.
  task automatic go(input exp_t e);
    if (e.cc) comb_q.push_back(e);
    reg_q.push_back(e);
    @(negedge clk);
  endtask

  // Combinational monitor: mid-cycle after the inputs settle.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (comb_q.size() != 0) begin
      e = comb_q.pop_front();
      chk("PCSrcE", {31'b0, bus.PCSrcE}, {31'b0, e.pcsrc});
      chk("PCTargetE", bus.PCTargetE, e.pct);
    end
  end

  // Register monitor: just after the capturing edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reg_q.size() != 0) begin
      e = reg_q.pop_front();
      chk("RegWriteM", {31'b0, bus.RegWriteM}, {31'b0, e.rw});
      chk("MemWriteM", {31'b0, bus.MemWriteM}, {31'b0, e.mw});
      chk("ResultSrcM", {31'b0, bus.ResultSrcM}, {31'b0, e.rs});
      chk("RD_M", {27'b0, bus.RD_M}, {27'b0, e.rd});
      if (e.cd) begin
        chk("ALUResultM", bus.ALUResultM, e.alu);
        chk("WriteDataM", bus.WriteDataM, e.wd);
        chk("PCPlus4M", bus.PCPlus4M, e.pc4);
      end
    end
  end

  initial begin
    exp_t hold;
    rst = 1'b0;
    bus.RegWriteE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0; bus.ALUSrcE = 0;
    bus.BranchE = 0; bus.ALUControlE = 3'b000; bus.RD1_E = 0; bus.RD2_E = 0;
    bus.Imm_Ext_E = 0; bus.RD_E = 0; bus.PCE = 0; bus.PCPlus4E = 0; bus.ResultW = 0;
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.StallE = 0; bus.FlushE = 0;
    @(negedge clk);

    // Reset held with live inputs and stall asserted
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.ResultSrcE = 1; bus.RD_E = 7;
    bus.RD1_E = 10; bus.RD2_E = 20; bus.Imm_Ext_E = 5; bus.PCE = 32'h40;
    bus.PCPlus4E = 32'h44; bus.StallE = 1;
    go(wc(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h45));
    bus.RD1_E = 11;
    go(mk(0, 0, 0, 0, 0, 0, 0));

    // Release: ADD x5 = 10 + 7
    rst = 1; bus.StallE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0; bus.RD_E = 5;
    bus.RD1_E = 10; bus.Imm_Ext_E = 7; bus.ALUSrcE = 1; bus.RD2_E = 32'h22;
    go(wc(mk(1, 0, 0, 5, 17, 32'h22, 32'h44), 1'b0, 32'h47));

    // Forward A from M (17+3), B from W
    bus.ForwardAE = 2'b10; bus.RD1_E = 0; bus.Imm_Ext_E = 3; bus.RD_E = 6;
    bus.RD2_E = 32'h33; bus.ForwardBE = 2'b01; bus.ResultW = 32'h55;
    go(wc(mk(1, 0, 0, 6, 20, 32'h55, 32'h44), 1'b0, 32'h43));

    // BEQ taken / not taken
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.BranchE = 1; bus.ALUControlE = 3'b001;
    bus.RD1_E = 32'h1234; bus.RD2_E = 32'h1234; bus.ALUSrcE = 0; bus.PCE = 32'h100;
    bus.PCPlus4E = 32'h104; bus.Imm_Ext_E = 32'hFFFF_FFF8; bus.RegWriteE = 0; bus.RD_E = 0;
    go(wc(mk(0, 0, 0, 0, 0, 32'h1234, 32'h104), 1'b1, 32'hF8));
    bus.RD2_E = 32'h1235;
    go(wc(mk(0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1235, 32'h104), 1'b0, 32'hF8));

    // ALU sweep
    bus.BranchE = 0; bus.ALUControlE = 3'b000; bus.RD1_E = 32'hFFFF_FFFF; bus.ALUSrcE = 1;
    bus.Imm_Ext_E = 1; bus.RD2_E = 0; bus.PCE = 32'h40; bus.PCPlus4E = 32'h44;
    bus.RegWriteE = 1; bus.RD_E = 1;
    go(wc(mk(1, 0, 0, 1, 0, 0, 32'h44), 1'b0, 32'h41));
    bus.ALUControlE = 3'b101; bus.RD_E = 2;
    go(mk(1, 0, 0, 2, 1, 0, 32'h44));
    bus.ALUControlE = 3'b111; bus.RD1_E = 32'h8000_0000; bus.RD_E = 3;
    go(mk(1, 0, 0, 3, 32'h4000_0000, 0, 32'h44));
    bus.ALUControlE = 3'b110; bus.RD1_E = 1; bus.Imm_Ext_E = 32'h21; bus.RD_E = 4;
    go(wc(mk(1, 0, 0, 4, 2, 0, 32'h44), 1'b0, 32'h61));
    bus.ALUControlE = 3'b100; bus.RD1_E = 32'hF0F0; bus.RD2_E = 32'h0FF0; bus.ALUSrcE = 0;
    bus.RD_E = 8;
    hold = mk(1, 0, 0, 8, 32'hFF00, 32'h0FF0, 32'h44);
    go(hold);

    // Stall three cycles with moving inputs
    bus.StallE = 1;
    for (int i = 0; i < 3; i++) begin
      bus.RD1_E = i * 3 + 1; bus.RD2_E = i; bus.RD_E = 5'(i + 20);
      bus.PCPlus4E = 32'h80 + i;
      go(hold);
    end

    // Flush beats stall
    bus.FlushE = 1; bus.MemWriteE = 1; bus.RegWriteE = 1; bus.ResultSrcE = 1; bus.RD_E = 9;
    bus.ALUControlE = 3'b000; bus.RD1_E = 1; bus.ALUSrcE = 1; bus.Imm_Ext_E = 2;
    bus.PCPlus4E = 32'h44;
    begin
      exp_t f = mk(0, 0, 0, 0, 0, 0, 0);
      f.cd = 0;
      go(f);
    end

    // Forward code 11 selects RF even with M/W holding a different value
    bus.FlushE = 0; bus.StallE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.RD1_E = 9; bus.Imm_Ext_E = 0; bus.RD_E = 10; bus.RD2_E = 0;
    go(mk(1, 0, 0, 10, 9, 0, 32'h44));
    bus.ForwardAE = 2'b11; bus.RD1_E = 4; bus.ResultW = 9;
    go(mk(1, 0, 0, 10, 4, 0, 32'h44));

    // OR, then AND with B forwarded from M into both SrcB and WriteData
    bus.ForwardAE = 2'b00; bus.ALUControlE = 3'b011; bus.RD1_E = 32'hF0; bus.Imm_Ext_E = 32'h0F;
    bus.RD2_E = 32'h77; bus.ResultSrcE = 1;
    go(mk(1, 0, 1, 10, 32'hFF, 32'h77, 32'h44));
    bus.ALUControlE = 3'b010; bus.ForwardBE = 2'b10; bus.ALUSrcE = 0;
    go(wc(mk(1, 0, 1, 10, 32'hF0, 32'hFF, 32'h44), 1'b0, 32'h4F));

    // Reset mid-stream, then resume
    rst = 0;
    go(mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1; bus.ForwardBE = 2'b00; bus.ALUControlE = 3'b000; bus.RD1_E = 1; bus.ALUSrcE = 1;
    bus.Imm_Ext_E = 1; bus.RD_E = 1; bus.ResultSrcE = 0; bus.RD2_E = 5; bus.MemWriteE = 1;
    go(mk(1, 1, 0, 1, 2, 5, 32'h44));

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(reg_q.size() + comb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage RV32I pipeline.
- Applies the ForwardAE/ForwardBE selects from the hazard unit to pick operands from the register file, the M-stage ALU result or the W-stage result.
- Performs ALU operations and resolves branch decision and target.
- Holds the E→M pipeline register. Its registered ALUResultM/RD_M/RegWriteM outputs feed back to the hazard unit and the forwarding path.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- RegWriteE  in  1  E-stage register-write control
- MemWriteE  in  1  E-stage store control
- ResultSrcE  in  1  0=ALU result, 1=load data (passed through)
- ALUSrcE  in  1  0=SrcB from forwarded RD2, 1=Imm_Ext_E
- BranchE  in  1  instruction is BEQ
- ALUControlE  in  3  ALU operation code
- RD1_E, RD2_E  in  XLEN  register-file read data
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  REG_AW  destination register
- PCE, PCPlus4E  in  XLEN  instruction PC and PC+4
- ResultW  in  XLEN  W-stage writeback value (forward source)
- ForwardAE, ForwardBE  in  2  00=RF, 01=ResultW, 10=ALUResultM, 11=RF
- StallE  in  1  hold E→M register contents
- FlushE  in  1  load bubble into E→M register
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  PCE+Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered controls
- RD_M  out  REG_AW  registered destination
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered data

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous, active-low. On a rising edge with rst=0, every registered output is cleared to 0. Combinational outputs follow their inputs during reset.
- Forwarding:
  - SrcA = mux(ForwardAE; RD1_E, ResultW, ALUResultM). Code 11 selects RD1_E.
  - FwdB = same mux on ForwardBE with RD2_E.
  - The 10 source is this block's own registered ALUResultM.
- Operand B: SrcB = ALUSrcE ? Imm_Ext_E : FwdB.
- ALU (XLEN-bit, wrap-around modulo 2^XLEN, no overflow flag):
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 slt (signed; result is 1 or 0, zero-extended)
  - 110 sll by SrcB[4:0], 111 srl by SrcB[4:0]
- Branch:
  - ZeroE = (ALUResult == 0).
  - PCSrcE = BranchE & ZeroE, combinational, same cycle. The decode stage is expected to set ALUControlE=001 for BEQ.
  - PCTargetE = PCE + Imm_Ext_E, wrap-around.
- E→M register, priority on each rising edge:
  1. rst=0 → all zero.
  2. FlushE=1 → RegWriteM=MemWriteM=ResultSrcM=0 and RD_M=0. Data fields are don't-care; they are loaded normally.
  3. StallE=1 → all registers hold.
  4. Otherwise load RegWriteE, MemWriteE, ResultSrcE, RD_E, ALUResult, FwdB (as WriteDataM), PCPlus4E.
- FlushE and StallE together → flush wins.
- WriteDataM is always the forwarded RD2 value, never the immediate.
- Latency: one cycle from E inputs to M outputs. PCSrcE/PCTargetE have zero latency.
- Reset mid-stream: the first edge with rst=0 clears the register regardless of StallE/FlushE. Normal loading resumes on the first edge after rst returns to 1.

Test Plan:
- Reset: rst=0 for 2 cycles with non-zero inputs and StallE=1 → all M outputs 0. Release rst; next edge loads the E inputs.
- Forward from M:
  - Cycle 1: ADD x5 with RD1_E=10, Imm=7, ALUSrcE=1 → ALUResultM=17.
  - Cycle 2: ForwardAE=10, RD1_E=0, ALUSrcE=1, Imm=3, add → ALUResultM=20.
  - ForwardBE=01 with ResultW=0x55 → WriteDataM=0x55.
- Branch: BranchE=1, sub, RD1_E=RD2_E=0x1234, PCE=0x100, Imm=-8 → PCSrcE=1, PCTargetE=0xF8. Repeat with RD2_E=0x1235 → PCSrcE=0.
- ALU sweep:
  - SrcA=0xFFFFFFFF, SrcB=1: add→0, slt→1.
  - SrcA=0x80000000, SrcB=1: srl→0x40000000.
  - SrcA=1, SrcB=0x21: sll uses shamt 1 → 2.
- Stall/flush:
  - StallE=1 for 3 cycles with changing inputs → M outputs frozen.
  - FlushE=1 with StallE=1, RegWriteE=1, MemWriteE=1 → RegWriteM=MemWriteM=0, RD_M=0.
- Forward code 11: ForwardAE=11, RD1_E=4, ResultW=9, ALUResultM=9, add with Imm=0 → ALUResultM=4.
